// File: rtl/snoop_bus_ctrl_if.sv
// Request/grant, snoop response, response queue and memory signals shared by
// the two Dcache controllers, the bus controller and memory.
interface snoop_bus_ctrl_if #(
    parameter int unsigned TAG_W = 56,
    parameter int unsigned IDX_W = 5
);
    logic [1:0]            dctrl_req_en_i;
    logic [1:0][TAG_W-1:0] dctrl_req_tag_i;
    logic [1:0][IDX_W-1:0] dctrl_req_idx_i;
    logic [1:0][63:0]      dctrl_req_data_i;
    logic [1:0][1:0]       dctrl_req_msg_i;
    logic                  bus_req_ack_o;
    logic                  bus_req_id_o;
    logic [TAG_W-1:0]      bus_req_tag_o;
    logic [IDX_W-1:0]      bus_req_idx_o;
    logic [1:0]            bus_req_msg_o;
    logic [1:0]            dctrl_rsp_vld_i;
    logic [1:0][63:0]      dctrl_rsp_data_i;
    logic                  bus_rsp_vld_o;
    logic                  bus_rsp_id_o;
    logic [63:0]           bus_rsp_data_o;
    logic [1:0]            dctrl_rsp_ack_i;
    logic                  mem_rdy_i;
    logic [1:0]            mem_cmd_o;
    logic [63:0]           mem_addr_o;
    logic [63:0]           mem_wr_data_o;
    logic                  mem_rsp_vld_i;
    logic [63:0]           mem_rsp_data_i;
    logic                  rspq_full_o;
    logic                  err_o;

    modport slave (
        input  dctrl_req_en_i, dctrl_req_tag_i, dctrl_req_idx_i, dctrl_req_data_i,
        input  dctrl_req_msg_i, dctrl_rsp_vld_i, dctrl_rsp_data_i, dctrl_rsp_ack_i,
        input  mem_rdy_i, mem_rsp_vld_i, mem_rsp_data_i,
        output bus_req_ack_o, bus_req_id_o, bus_req_tag_o, bus_req_idx_o, bus_req_msg_o,
        output bus_rsp_vld_o, bus_rsp_id_o, bus_rsp_data_o,
        output mem_cmd_o, mem_addr_o, mem_wr_data_o, rspq_full_o, err_o
    );

    modport master (
        output dctrl_req_en_i, dctrl_req_tag_i, dctrl_req_idx_i, dctrl_req_data_i,
        output dctrl_req_msg_i, dctrl_rsp_vld_i, dctrl_rsp_data_i, dctrl_rsp_ack_i,
        output mem_rdy_i, mem_rsp_vld_i, mem_rsp_data_i,
        input  bus_req_ack_o, bus_req_id_o, bus_req_tag_o, bus_req_idx_o, bus_req_msg_o,
        input  bus_rsp_vld_o, bus_rsp_id_o, bus_rsp_data_o,
        input  mem_cmd_o, mem_addr_o, mem_wr_data_o, rspq_full_o, err_o
    );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// Two-core snooping bus controller: round-robin grant broadcast, memory
// load/store sourcing, and an in-order GET_S response queue.
module snoop_bus_ctrl #(
    parameter int unsigned TAG_W      = 56,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned RSPQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    snoop_bus_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(RSPQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        MSG_NONE  = 2'd0,
        MSG_GET_S = 2'd1,
        MSG_GET_M = 2'd2,
        MSG_PUT_M = 2'd3
    } message_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } mem_cmd_t;

    typedef struct packed {
        logic        id;
        logic        rdy;
        logic        wait_mem;
        logic [63:0] data;
    } rspq_entry_t;

    rspq_entry_t      q     [RSPQ_DEPTH];
    rspq_entry_t      q_nxt [RSPQ_DEPTH];
    logic [PTR_W-1:0] head, head_nxt, tail, tail_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             rr, rr_nxt;
    logic             err, err_nxt;

    logic [1:0]       elig;
    logic             grant, gid, peer_hit, push, pop, full;
    message_t         gmsg;
    logic             fill_hit;
    logic [PTR_W-1:0] fill_ptr, scan_ptr;

    // Queue/pointer/arbiter state; everything clears on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RSPQ_DEPTH; i++) q[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rr    <= 1'b0;
            err   <= 1'b0;
        end else begin
            for (int i = 0; i < RSPQ_DEPTH; i++) q[i] <= q_nxt[i];
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
            rr    <= rr_nxt;
            err   <= err_nxt;
        end
    end

    // Arbitration, broadcast, memory command and queue next-state
    always_comb begin
        elig      = 2'b00;
        full      = (count == CNT_W'(RSPQ_DEPTH));
        grant     = 1'b0;
        gid       = 1'b0;
        gmsg      = MSG_NONE;
        peer_hit  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        fill_hit  = 1'b0;
        fill_ptr  = '0;
        scan_ptr  = '0;
        q_nxt     = q;
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        rr_nxt    = rr;
        err_nxt   = err;

        bus.bus_req_ack_o  = 1'b0;
        bus.bus_req_id_o   = 1'b0;
        bus.bus_req_tag_o  = '0;
        bus.bus_req_idx_o  = '0;
        bus.bus_req_msg_o  = MSG_NONE;
        bus.mem_cmd_o      = CMD_NONE;
        bus.mem_addr_o     = '0;
        bus.mem_wr_data_o  = '0;

        // Eligibility uses the registered full flag, so a pop never opens a GET_S slot early
        for (int c = 0; c < 2; c++) begin
            if (rst && bus.dctrl_req_en_i[c]) begin
                unique case (message_t'(bus.dctrl_req_msg_i[c]))
                    MSG_GET_M: elig[c] = 1'b1;
                    MSG_PUT_M: elig[c] = bus.mem_rdy_i;
                    MSG_GET_S: elig[c] = bus.mem_rdy_i && !full;
                    default:   elig[c] = 1'b0;
                endcase
            end
        end

        grant = |elig;
        gid   = (elig == 2'b11) ? ~rr : elig[1];

        if (grant) begin
            gmsg     = message_t'(bus.dctrl_req_msg_i[gid]);
            peer_hit = bus.dctrl_rsp_vld_i[~gid];
            rr_nxt   = gid;
            bus.bus_req_ack_o = 1'b1;
            bus.bus_req_id_o  = gid;
            bus.bus_req_tag_o = bus.dctrl_req_tag_i[gid];
            bus.bus_req_idx_o = bus.dctrl_req_idx_i[gid];
            bus.bus_req_msg_o = gmsg;
            if (gmsg == MSG_PUT_M || gmsg == MSG_GET_S)
                bus.mem_addr_o = 64'({bus.dctrl_req_tag_i[gid], bus.dctrl_req_idx_i[gid], 3'b000});
            if (gmsg == MSG_PUT_M) begin
                bus.mem_cmd_o     = CMD_STORE;
                bus.mem_wr_data_o = bus.dctrl_req_data_i[gid];
            end else if (gmsg == MSG_GET_S) begin
                push = 1'b1;
                if (peer_hit) begin
                    bus.mem_cmd_o     = CMD_STORE;
                    bus.mem_wr_data_o = bus.dctrl_rsp_data_i[~gid];
                end else begin
                    bus.mem_cmd_o = CMD_LOAD;
                end
            end
        end

        // Loads return in order, so the oldest waiting entry owns the memory data
        for (int i = 0; i < RSPQ_DEPTH; i++) begin
            scan_ptr = head + PTR_W'(i);
            if (!fill_hit && (CNT_W'(i) < count) && q[scan_ptr].wait_mem) begin
                fill_hit = 1'b1;
                fill_ptr = scan_ptr;
            end
        end
        if (bus.mem_rsp_vld_i) begin
            if (fill_hit) begin
                q_nxt[fill_ptr].data     = bus.mem_rsp_data_i;
                q_nxt[fill_ptr].rdy      = 1'b1;
                q_nxt[fill_ptr].wait_mem = 1'b0;
            end else begin
                err_nxt = 1'b1;
            end
        end

        bus.bus_rsp_vld_o  = (count != '0) && q[head].rdy;
        bus.bus_rsp_id_o   = q[head].id;
        bus.bus_rsp_data_o = q[head].data;
        pop = bus.bus_rsp_vld_o && bus.dctrl_rsp_ack_i[q[head].id];

        if (push) begin
            q_nxt[tail].id       = gid;
            q_nxt[tail].rdy      = peer_hit;
            q_nxt[tail].wait_mem = !peer_hit;
            q_nxt[tail].data     = peer_hit ? bus.dctrl_rsp_data_i[~gid] : 64'd0;
            tail_nxt             = tail + PTR_W'(1);
        end
        if (pop) begin
            q_nxt[head].rdy = 1'b0;
            head_nxt        = head + PTR_W'(1);
        end
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);

        bus.rspq_full_o = full;
        bus.err_o       = err;
    end
endmodule
